// File: rtl/sc_rr_crossbar_arbiter.sv
// Two-master / two-slave crossbar arbiter: routes each master to the slave picked by
// one address bit, round-robins same-slave conflicts, and holds the path until acked.
module sc_rr_crossbar_arbiter #(
  parameter int unsigned SEL_BIT = 31,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_ms_0,
  input  logic        i_req_ms_1,
  input  logic [31:0] i_addr_ms_0,
  input  logic [31:0] i_addr_ms_1,
  input  logic        i_ack_sl_0,
  input  logic        i_ack_sl_1,
  output logic        o_cross_connect,
  output logic        o_sl_0_connect,
  output logic        o_sl_1_connect,
  output logic        o_grant_ms_0,
  output logic        o_grant_ms_1,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        cross_q, cross_d;
  logic [1:0]  conn_q, conn_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  logic       t0, t1;
  logic [1:0] ack, pend_left;
  logic       unused_addr;

  assign t0  = i_addr_ms_0[SEL_BIT];
  assign t1  = i_addr_ms_1[SEL_BIT];
  assign ack = {i_ack_sl_1, i_ack_sl_0};
  assign unused_addr = ^{i_addr_ms_0, i_addr_ms_1};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cross_d   = cross_q;
    conn_d    = conn_q;
    grant_d   = grant_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    tmo_d     = 1'b0;
    cnt_d     = cnt_q;
    // Acks only matter for slaves still owed one; stray acks fall out here.
    pend_left = pend_q & ~ack;
    case (state_q)
      ST_IDLE: begin
        conn_d  = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        pend_d  = '0;
        if (i_req_ms_0 && i_req_ms_1 && (t0 != t1)) begin
          cross_d = t0;
          conn_d  = 2'b11;
          grant_d = 2'b11;
        end else if (i_req_ms_0 && (!i_req_ms_1 || !ptr_q)) begin
          cross_d    = t0;
          conn_d[t0] = 1'b1;
          grant_d    = 2'b01;
          if (i_req_ms_1) ptr_d = 1'b1;
        end else if (i_req_ms_1) begin
          cross_d    = ~t1;
          conn_d[t1] = 1'b1;
          grant_d    = 2'b10;
          if (i_req_ms_0) ptr_d = 1'b0;
        end
        if (grant_d != 2'b00) begin
          state_d = ST_BUSY;
          busy_d  = 1'b1;
          pend_d  = conn_d;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // Completion wins over a watchdog expiry landing on the same edge.
        if (pend_left == 2'b00) begin
          state_d = ST_IDLE;
          conn_d  = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          pend_d  = '0;
        end else if ((TIMEOUT != 0) && (cnt_d == TMO)) begin
          // Flags drop now; the empty pending set retires BUSY on the next edge.
          tmo_d  = 1'b1;
          pend_d = '0;
        end else begin
          pend_d = pend_left;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      cross_q <= 1'b0;
      conn_q  <= '0;
      grant_q <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cross_q <= cross_d;
      conn_q  <= conn_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_cross_connect = cross_q;
  assign o_sl_0_connect  = conn_q[0];
  assign o_sl_1_connect  = conn_q[1];
  assign o_grant_ms_0    = grant_q[0];
  assign o_grant_ms_1    = grant_q[1];
  assign o_busy          = busy_q;
  assign o_timeout       = tmo_q;

endmodule

// File: doc/sc_rr_crossbar_arbiter.md
SC_RR_CROSSBAR_ARBITER -- requirements
Module: sc_rr_crossbar_arbiter

Interface
REQ-001 Parameter SEL_BIT, default 31: master address bit that selects the target slave (0 -> slave 0, 1 -> slave 1).
REQ-002 Parameter TIMEOUT, default 255: maximum BUSY cycles before a forced release; 0 disables the watchdog.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_req_ms_0 / i_req_ms_1  in  1  master request; held high until the master sees its ack.
REQ-007 i_addr_ms_0 / i_addr_ms_1  in  32  master address; only bit SEL_BIT is used.
REQ-008 i_ack_sl_0 / i_ack_sl_1  in  1  single-cycle slave ack pulse.
REQ-009 o_cross_connect  out  1  0 = ms0->sl0 and ms1->sl1; 1 = ms0->sl1 and ms1->sl0; drives the crossbar matrix.
REQ-010 o_sl_0_connect / o_sl_1_connect  out  1  slave enable to the crossbar matrix; a low value gates req/cmd to that slave.
REQ-011 o_grant_ms_0 / o_grant_ms_1  out  1  master currently owns a path.
REQ-012 o_busy  out  1  high while in BUSY.
REQ-013 o_timeout  out  1  single-cycle pulse on watchdog release.

Function
REQ-014 All outputs SHALL be registered; states are IDLE and BUSY.
REQ-015 In IDLE, with t0 = i_addr_ms_0[SEL_BIT] and t1 = i_addr_ms_1[SEL_BIT], the arbiter SHALL evaluate the requests; the resulting grant appears one cycle later, together with BUSY.
REQ-016 No request: the block SHALL stay in IDLE with all connect and grant outputs 0; o_cross_connect holds its last value.
REQ-017 Only ms0 requests: cross = t0, connect slave t0, grant ms0.
REQ-018 Only ms1 requests: cross = ~t1, connect slave t1, grant ms1.
REQ-019 Both request with t0 != t1: cross = t0, connect both slaves, grant both; the round-robin pointer SHALL be unchanged.
REQ-020 Both request with t0 == t1 (conflict): grant the master named by the pointer only; cross follows REQ-017/018 for the winner; the pointer SHALL toggle to the loser.
REQ-021 The round-robin pointer SHALL reset to 0 (ms0 preferred).
REQ-022 On entry to BUSY, a pending flag SHALL be set per connected slave; the flag clears on that slave's i_ack_sl_x.
REQ-023 Acks from unconnected slaves, or acks in IDLE, SHALL be ignored.
REQ-024 Simultaneous acks from both slaves in one cycle SHALL clear both flags.
REQ-025 In the cycle after the last pending flag clears, the block SHALL return to IDLE: connects, grants and o_busy go 0.
REQ-026 The ack-cycle connection SHALL be held, so the ack reaches the master through the matrix.
REQ-027 o_cross_connect and the connect bits SHALL be stable throughout BUSY; requests arriving during BUSY are not evaluated until IDLE.
REQ-028 A losing master's request SHALL remain pending and be served on the next IDLE evaluation; with the pointer rule, starvation is bounded to one transaction.
REQ-029 A request still high in the first IDLE cycle after its ack SHALL be treated as a new request.
REQ-030 Watchdog: a 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-031 When the counter reaches TIMEOUT (TIMEOUT > 0): force IDLE next cycle, clear all pending flags, pulse o_timeout for 1 cycle, and leave the pointer unchanged.
REQ-032 A watchdog timeout coinciding with the final ack SHALL be treated as normal completion, with no o_timeout pulse.

Reset
REQ-033 While i_rst is high at a clock edge: state = IDLE; all outputs = 0, including o_cross_connect; pointer = 0; pending flags and counter = 0.
REQ-034 Reset asserted mid-BUSY SHALL drop all connects on the next edge and discard the pending transaction.
REQ-035 The first evaluation after reset SHALL be in the cycle following reset deassertion.

Verification
REQ-036 ms0 alone, addr=0x8000_0000 -> next cycle cross=1, sl_1_connect=1, sl_0_connect=0, grant_ms_0=1; ack_sl_1 3 cycles later -> IDLE one cycle after the ack.
REQ-037 Both request, addr0=0x0, addr1=0x8000_0000 -> cross=0, both connects=1; ack_sl_1 first, then ack_sl_0 2 cycles later -> block stays BUSY until the second ack.
REQ-038 Both target sl0 for 3 back-to-back rounds -> grants alternate ms0, ms1, ms0; cross alternates 0, 1, 0; sl_1_connect stays 0.
REQ-039 TIMEOUT=4 with a grant and no ack -> o_timeout pulses in the 5th BUSY cycle; connects=0 on the next cycle; a stray ack afterwards is ignored.
REQ-040 i_rst asserted in the 2nd BUSY cycle -> all outputs 0 next edge; after release, a pending conflict grants ms0 first.
REQ-041 Ack on an unconnected slave during BUSY -> no state change.
